// File: rtl/plantard_unscale.sv
// Streaming (a * K) mod Q multiplier built on Plantard reduction, with valid/ready flow control and polynomial framing.
// Optional build macro PLANTARD_UNSCALE_OUT_REG_EN adds a register after the final r==Q correction.
module plantard_unscale #(
    parameter int data_width = 12,
    parameter int Q          = 3329,
    parameter int K          = 1441,
    parameter int N          = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_err
);

    localparam int L  = 13;              // Plantard half-width; 2L = 26
    localparam int PW = data_width + L;  // product width (25)
    localparam int SW = PW + L;          // shifted-sum width (38)
    localparam int MW = 2 * L;           // width of m + Q (26)
    localparam int CW = $clog2(N);

    // PK = ((K * -2^2L) mod Q) * Q^-1 mod 2^2L, evaluated at elaboration.
    function automatic logic [2*L-1:0] plantard_const(input int unsigned q, input int unsigned k);
        longint unsigned qq, kk, mask, r2, kneg, inv, pk;
        qq   = {32'd0, q};
        kk   = {32'd0, k};
        mask = (64'd1 << (2 * L)) - 64'd1;
        r2   = (64'd1 << (2 * L)) % qq;
        kneg = (qq - ((kk * r2) % qq)) % qq;
        // Newton iteration for Q^-1 mod 2^2L: an odd q is its own inverse mod 8,
        // and each step doubles the number of correct low bits.
        inv = qq;
        for (int i = 0; i < 5; i++) begin
            inv = (inv * (64'd2 - qq * inv)) & mask;
        end
        pk = (kneg * inv) & mask;
        return pk[2*L-1:0];
    endfunction

    localparam logic [2*L-1:0] PK = plantard_const(Q, K);

    if (K < 0 || K >= Q) begin : g_bad_k
        $error("plantard_unscale: K must satisfy 0 <= K < Q");
    end
    if (Q % 2 == 0 || Q >= (1 << L) || Q >= (1 << data_width)) begin : g_bad_q
        $error("plantard_unscale: Q must be odd and fit in both L and data_width bits");
    end
    if (data_width + L > MW) begin : g_bad_width
        $error("plantard_unscale: data_width too wide for the 2L-bit reduction");
    end

    // Global advance: the whole pipe moves only when the output slot frees up.
    logic adv;
    logic take;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign take     = in_valid & adv;

    logic [data_width-1:0] s0_a;
    logic                  s0_valid, s0_last;
    logic [PW-1:0]         s1_pl, s1_ph;
    logic                  s1_valid, s1_last;
    logic [L-1:0]          s2_t;
    logic                  s2_valid, s2_last;
    logic [PW-1:0]         s3_m;
    logic                  s3_valid, s3_last;
    logic [L-1:0]          s4_r;
    logic                  s4_valid, s4_last;

    logic [SW-1:0] s2_sum;
    logic [MW-1:0] s4_mq;
    logic [L-1:0]  corr;

    assign s2_sum = {s1_ph, {L{1'b0}}} + SW'(s1_pl);
    assign s4_mq  = MW'(s3_m) + MW'(Q);
    assign corr   = (s4_r == L'(Q)) ? '0 : s4_r;

    logic unused_bits;
    assign unused_bits = ^{s2_sum[L-1:0], s2_sum[SW-1:2*L], s4_mq[L-1:0], corr[L-1:data_width]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well as valids, so out_data reads 0 during reset.
            s0_a     <= '0;
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s1_pl    <= '0;
            s1_ph    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_t     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s3_m     <= '0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s4_r     <= '0;
            s4_valid <= 1'b0;
            s4_last  <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            s0_a     <= in_data;
            s0_valid <= in_valid;
            s0_last  <= in_valid & in_last;

            s1_pl    <= PW'(s0_a) * PW'(PK[L-1:0]);
            s1_ph    <= PW'(s0_a) * PW'(PK[2*L-1:L]);
            s1_valid <= s0_valid;
            s1_last  <= s0_last;

            s2_t     <= s2_sum[2*L-1:L];
            s2_valid <= s1_valid;
            s2_last  <= s1_last;

            s3_m     <= PW'(s2_t) * PW'(Q);
            s3_valid <= s2_valid;
            s3_last  <= s2_last;

            s4_r     <= s4_mq[2*L-1:L];
            s4_valid <= s3_valid;
            s4_last  <= s3_last;
        end
    end

`ifdef PLANTARD_UNSCALE_OUT_REG_EN
    logic [data_width-1:0] s5_data;
    logic                  s5_valid, s5_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s5_data  <= '0;
            s5_valid <= 1'b0;
            s5_last  <= 1'b0;
        end else if (adv) begin
            s5_data  <= corr[data_width-1:0];
            s5_valid <= s4_valid;
            s5_last  <= s4_last;
        end
    end

    assign out_data  = s5_data;
    assign out_valid = s5_valid;
    assign out_last  = s5_last;
`else
    assign out_data  = corr[data_width-1:0];
    assign out_valid = s4_valid;
    assign out_last  = s4_last;
`endif

    // Framing: a frame ends on in_last or after N coefficients; the two must coincide.
    logic [CW-1:0] cnt;
    logic          at_end;
    assign at_end = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else if (take) begin
            cnt <= (in_last || at_end) ? '0 : cnt + 1'b1;
            if (in_last != at_end) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
